// File: rtl/systolic_feeder.sv
// Operand feeder for the systolic MXU: per-channel north/west buffers streamed with diagonal skew.
// Optional macro FEEDER_STALL_EN adds a stall input that freezes RUN/DRAIN progress.
module systolic_feeder #(
  parameter int NUM_SIZE     = 16,
  parameter int GRID_SIZE    = 2,
  parameter int BUFFER_LEN   = 32,
  parameter int ADDRESS_LEN  = 5,
  parameter int DRAIN_CYCLES = 3,
  localparam int CHAN_W      = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [CHAN_W-1:0]             wr_chan,
  input  logic [ADDRESS_LEN-1:0]        wr_addr,
  input  logic [NUM_SIZE-1:0]           wr_data,
  input  logic [ADDRESS_LEN:0]          len,
  input  logic                          start,
`ifdef FEEDER_STALL_EN
  input  logic                          stall,
`endif
  output logic [NUM_SIZE*GRID_SIZE-1:0] north_input,
  output logic [NUM_SIZE*GRID_SIZE-1:0] west_input,
  output logic                          ce,
  output logic                          busy,
  output logic                          done
);

  localparam int LEN_W      = ADDRESS_LEN + 1;
  localparam int STEP_W     = $clog2(BUFFER_LEN + GRID_SIZE) + 1;
  localparam int DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [STEP_W-1:0]             step_reg, step_next;
  logic [DRAIN_W-1:0]            drain_reg, drain_next;
  logic [LEN_W-1:0]              len_reg, len_next;
  logic [LEN_W-1:0]              len_clamped;
  logic [STEP_W-1:0]             last_step;
  logic                          hold;
  logic                          stall_in;
  logic                          wr_ok;
  logic [NUM_SIZE*GRID_SIZE-1:0] north_rd, west_rd;
  logic [NUM_SIZE*GRID_SIZE-1:0] north_reg, west_reg;
  logic                          ce_reg, busy_reg, done_reg;

`ifdef FEEDER_STALL_EN
  assign stall_in = stall;
`else
  assign stall_in = 1'b0;
`endif

  assign wr_ok       = (state_reg == IDLE) && wr_en;
  assign len_clamped = (len > LEN_W'(BUFFER_LEN)) ? LEN_W'(BUFFER_LEN) : len;
  assign last_step   = STEP_W'(len_reg) + STEP_W'(GRID_SIZE - 2);

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    drain_next = drain_reg;
    len_next   = len_reg;
    hold       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next = len_clamped;
          if (len_clamped == '0) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
            step_next  = '0;
          end
        end
      end
      RUN: begin
        if (stall_in) begin
          hold = 1'b1;
        end else if (step_reg == last_step) begin
          drain_next = '0;
          state_next = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else begin
          step_next = step_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (stall_in) begin
          hold = 1'b1;
        end else if (drain_reg == DRAIN_W'(DRAIN_LAST)) begin
          state_next = DONE;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next step, so a registered step t is on the buses in the same cycle.
  for (genvar gi = 0; gi < GRID_SIZE; gi++) begin : g_chan
    logic [NUM_SIZE-1:0]    north_mem [BUFFER_LEN];
    logic [NUM_SIZE-1:0]    west_mem  [BUFFER_LEN];
    logic                   wr_hit_n, wr_hit_w;
    logic [STEP_W:0]        rel_ext;
    logic                   in_window;
    logic [ADDRESS_LEN-1:0] rd_addr;
    logic [NUM_SIZE-1:0]    north_val, west_val;

    assign wr_hit_n = wr_ok && !wr_sel && (wr_chan == CHAN_W'(gi));
    assign wr_hit_w = wr_ok &&  wr_sel && (wr_chan == CHAN_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < BUFFER_LEN; k++) begin
          north_mem[k] <= '0;
          west_mem[k]  <= '0;
        end
      end else begin
        if (wr_hit_n) north_mem[wr_addr] <= wr_data;
        if (wr_hit_w) west_mem[wr_addr]  <= wr_data;
      end
    end

    // Sign bit of the widened difference flags t < i; the low bits wrap safely into the buffer.
    assign rel_ext   = {1'b0, step_next} - (STEP_W + 1)'(gi);
    assign in_window = !rel_ext[STEP_W] && (rel_ext[STEP_W-1:0] < STEP_W'(len_next));
    assign rd_addr   = rel_ext[ADDRESS_LEN-1:0];

    // A write landing on the same edge as start must be visible in step 0.
    always_comb begin
      north_val = '0;
      west_val  = '0;
      if (in_window) begin
        north_val = (wr_hit_n && wr_addr == rd_addr) ? wr_data : north_mem[rd_addr];
        west_val  = (wr_hit_w && wr_addr == rd_addr) ? wr_data : west_mem[rd_addr];
      end
    end

    assign north_rd[gi*NUM_SIZE +: NUM_SIZE] = north_val;
    assign west_rd[gi*NUM_SIZE +: NUM_SIZE]  = west_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      drain_reg <= '0;
      len_reg   <= '0;
      north_reg <= '0;
      west_reg  <= '0;
      ce_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      drain_reg <= drain_next;
      len_reg   <= len_next;
      ce_reg    <= ((state_next == RUN) || (state_next == DRAIN)) && !hold;
      busy_reg  <= (state_next == RUN) || (state_next == DRAIN);
      done_reg  <= (state_next == DONE);
      if (!hold) begin
        north_reg <= (state_next == RUN) ? north_rd : '0;
        west_reg  <= (state_next == RUN) ? west_rd  : '0;
      end
    end
  end

  assign north_input = north_reg;
  assign west_input  = west_reg;
  assign ce          = ce_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed-plus-random bench for systolic_feeder; expected buses come from a buffer-array model.
module tb_systolic_feeder;
  localparam int NS = 16, G = 2, BL = 32, AL = 5, D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, wr_sel, start;
  logic [0:0]    wr_chan;
  logic [AL-1:0] wr_addr;
  logic [NS-1:0] wr_data;
  logic [AL:0]   len;
`ifdef FEEDER_STALL_EN
  logic          stall;
`endif
  logic [NS*G-1:0] north_input, west_input;
  logic            ce, busy, done;

  int checks = 0;
  int failures = 0;
  logic [NS-1:0] nmem [G][BL];
  logic [NS-1:0] wmem [G][BL];

  systolic_feeder #(.NUM_SIZE(NS), .GRID_SIZE(G), .BUFFER_LEN(BL),
                    .ADDRESS_LEN(AL), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_chan(wr_chan),
    .wr_addr(wr_addr), .wr_data(wr_data), .len(len), .start(start),
`ifdef FEEDER_STALL_EN
    .stall(stall),
`endif
    .north_input(north_input), .west_input(west_input),
    .ce(ce), .busy(busy), .done(done));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand seen on channel ch, c cycles after the run starts (drain cycles and skew gaps give 0).
  function automatic logic [NS-1:0] exp_bus(input bit w, input int ch, input int c, input int l);
    int idx;
    idx = c - ch;
    if (c >= l + G - 1 || idx < 0 || idx >= l) return '0;
    return w ? wmem[ch][idx % BL] : nmem[ch][idx % BL];
  endfunction

  task automatic wr(input bit sel, input int ch, input int addr, input logic [NS-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_chan = 1'(ch); wr_addr = AL'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel) wmem[ch][addr] = data; else nmem[ch][addr] = data;
  endtask

  task automatic chk_buses(input string tag, input int c, input int l);
    for (int ch = 0; ch < G; ch++) begin
      chk($sformatf("%s north ch%0d c%0d", tag, ch, c), 64'(north_input[ch*NS +: NS]), 64'(exp_bus(0, ch, c, l)));
      chk($sformatf("%s west ch%0d c%0d", tag, ch, c), 64'(west_input[ch*NS +: NS]), 64'(exp_bus(1, ch, c, l)));
    end
  endtask

  // Issues start with len_req and checks every cycle through the done pulse.
  task automatic do_run(input int len_req, input int inj_cycle, input int stall_at, input int stall_n);
    int l, ncyc;
    l = (len_req > BL) ? BL : len_req;
    $display("run len=%0d effective=%0d inject=%0d stall_at=%0d", len_req, l, inj_cycle, stall_at);
    start = 1'b1; len = (AL+1)'(len_req);
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (l == 0) begin
      chk("len0 done", 64'(done), 64'd1);
      chk("len0 ce", 64'(ce), 64'd0);
      chk("len0 busy", 64'(busy), 64'd0);
      tick();
      chk("len0 done after", 64'(done), 64'd0);
      chk("len0 ce after", 64'(ce), 64'd0);
      return;
    end
    ncyc = l + G - 1 + D;
    for (int c = 0; c < ncyc; c++) begin
      chk($sformatf("run ce c%0d", c), 64'(ce), 64'd1);
      chk($sformatf("run busy c%0d", c), 64'(busy), 64'd1);
      chk($sformatf("run done c%0d", c), 64'(done), 64'd0);
      chk_buses("run", c, l);
      if (c == inj_cycle) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_chan = 1'b0; wr_addr = '0; wr_data = 16'd99;
        start = 1'b1; len = 6'd2;
      end
`ifdef FEEDER_STALL_EN
      if (c == stall_at) begin
        stall = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk($sformatf("stall ce s%0d", s), 64'(ce), 64'd0);
          chk($sformatf("stall busy s%0d", s), 64'(busy), 64'd1);
          chk_buses("stall", c, l);
        end
        stall = 1'b0;
      end
`endif
      tick();
      wr_en = 1'b0; start = 1'b0;
    end
    chk("end done", 64'(done), 64'd1);
    chk("end ce", 64'(ce), 64'd0);
    chk("end busy", 64'(busy), 64'd0);
    chk("end north", 64'(north_input), 64'd0);
    chk("end west", 64'(west_input), 64'd0);
    tick();
    chk("after done", 64'(done), 64'd0);
    chk("after busy", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int ch = 0; ch < G; ch++)
      for (int a = 0; a < BL; a++) begin
        nmem[ch][a] = '0;
        wmem[ch][a] = '0;
      end
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_chan = '0; wr_addr = '0;
    wr_data = '0; len = '0; start = 1'b0;
`ifdef FEEDER_STALL_EN
    stall = 1'b0;
`endif
    #3;
    chk("reset ce", 64'(ce), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset north", 64'(north_input), 64'd0);
    chk("reset west", 64'(west_input), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Skew pattern: north 1..6, west 7..12.
    for (int k = 0; k < 3; k++) begin
      wr(0, 0, k, NS'(1 + k));
      wr(0, 1, k, NS'(4 + k));
      wr(1, 0, k, NS'(7 + k));
      wr(1, 1, k, NS'(10 + k));
    end
    do_run(3, -1, -1, 0);

    do_run(0, -1, -1, 0);

    // Random fill, then the clamped full-buffer run.
    for (int ch = 0; ch < G; ch++)
      for (int a = 0; a < BL; a++) begin
        wr(0, ch, a, NS'($urandom));
        wr(1, ch, a, NS'($urandom));
      end
    do_run(40, -1, -1, 0);

    for (int r = 0; r < 4; r++) begin
      wr(r % 2, $urandom_range(0, G - 1), $urandom_range(0, BL - 1), NS'($urandom));
      do_run($urandom_range(1, 40), -1, -1, 0);
    end

    // Write and start in the same idle cycle: step 0 must already see the new value.
    wr_en = 1'b1; wr_sel = 1'b0; wr_chan = 1'b0; wr_addr = '0; wr_data = 16'hBEEF;
    nmem[0][0] = 16'hBEEF;
    do_run(4, -1, -1, 0);

    // Mid-run write and start are ignored.
    do_run(5, 2, -1, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle busy k%0d", k), 64'(busy), 64'd0);
      chk($sformatf("idle done k%0d", k), 64'(done), 64'd0);
      tick();
    end
    do_run(1, -1, -1, 0);

    // Asynchronous reset at run step 2.
    start = 1'b1; len = 6'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst ce", 64'(ce), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst north", 64'(north_input), 64'd0);
    chk("midrst west", 64'(west_input), 64'd0);
    tick();
    chk("midrst done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();
    chk("postrst done", 64'(done), 64'd0);
    for (int ch = 0; ch < G; ch++)
      for (int a = 0; a < BL; a++) begin
        nmem[ch][a] = '0;
        wmem[ch][a] = '0;
      end
    do_run(6, -1, -1, 0);

`ifdef FEEDER_STALL_EN
    for (int k = 0; k < 3; k++) begin
      wr(0, 0, k, NS'(1 + k));
      wr(0, 1, k, NS'(4 + k));
      wr(1, 0, k, NS'(7 + k));
      wr(1, 1, k, NS'(10 + k));
    end
    do_run(3, -1, 1, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Parametrised operand feeder and sequencer for the systolic MXU.
- Holds GRID_SIZE north and GRID_SIZE west operand buffers, each BUFFER_LEN deep, loaded through a write port.
- On start, streams operands with per-channel diagonal skew (channel i delayed i cycles) and drives the MXU clock-enable through run and drain phases.
- Signals completion, with programmable stream length and wrap-safe indexing.

Parameters:
- NUM_SIZE, 16: operand width in bits.
- GRID_SIZE, 2: MXU rows/columns; also the number of north and west channels.
- BUFFER_LEN, 32: entries per channel buffer; must be a power of 2.
- ADDRESS_LEN, 5: log2(BUFFER_LEN); width of buffer addresses.
- DRAIN_CYCLES, 3: extra ce cycles after the last skewed operand, letting partial sums settle.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: buffer write strobe.
- wr_sel, input, 1: write target; 0 = north buffers, 1 = west buffers.
- wr_chan, input, $clog2(GRID_SIZE) (min 1): target channel.
- wr_addr, input, ADDRESS_LEN: target entry.
- wr_data, input, NUM_SIZE: write data.
- len, input, ADDRESS_LEN+1: stream length, sampled on start.
- start, input, 1: single-cycle request to begin a run.
- north_input, output, NUM_SIZE*GRID_SIZE: skewed north operands to the MXU; channel i occupies bits [(i+1)*NUM_SIZE-1 : i*NUM_SIZE].
- west_input, output, NUM_SIZE*GRID_SIZE: skewed west operands, same packing.
- ce, output, 1: MXU clock-enable.
- busy, output, 1: high in RUN and DRAIN.
- done, output, 1: one-cycle pulse at the end of a run.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; step and drain counters = 0.
  - All buffer entries = 0.
  - Outputs: north_input=0, west_input=0, ce=0, busy=0, done=0.
  - Reset mid-run aborts immediately, with no done pulse.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - wr_en writes buffer[wr_sel][wr_chan][wr_addr] = wr_data.
  - wr_chan >= GRID_SIZE: write dropped.
  - start=1 latches L = min(len, BUFFER_LEN).
  - L=0: go to DONE.
  - Otherwise: step = 0, go to RUN.
  - If start and wr_en arrive in the same IDLE cycle, the write completes first.
- RUN:
  - Each cycle, step t runs 0 .. L+GRID_SIZE-2.
  - Channel i drives buffer[i][t-i] when 0 <= t-i < L, else 0. The same rule applies to north and west.
  - Buffer index is computed modulo BUFFER_LEN; it never reads out of range.
  - ce=1 and busy=1.
  - Registered outputs for step t appear in the cycle after step t is selected; the first cycle after start is accepted shows step 0 with ce=1.
  - After step L+GRID_SIZE-2, go to DRAIN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles with buses = 0, ce=1, busy=1.
  - DRAIN_CYCLES=0 skips DRAIN and goes straight to DONE.
- DONE:
  - One cycle: done=1, ce=0, busy=0, buses = 0.
  - Next state is IDLE.
- Run length: total ce-high cycles = L + GRID_SIZE - 1 + DRAIN_CYCLES.
- Ignored inputs:
  - start while busy or in DONE is ignored.
  - wr_en while busy or in DONE is ignored; buffer contents stay frozen during a run.
- len > BUFFER_LEN is clamped to BUFFER_LEN.
- Buffers are not cleared between runs.

Optional Feature:
- Macro: FEEDER_STALL_EN.
- When defined:
  - Adds input stall (1 bit).
  - While stall=1 in RUN or DRAIN: ce=0, step/drain counters hold, buses hold their last value. Resumes exactly where it paused.
  - stall is ignored in IDLE and DONE.
- When undefined: no stall port; counters advance every cycle in RUN and DRAIN.

Test Plan:
- Skew check: GRID_SIZE=2, DRAIN_CYCLES=3; north ch0 = 1,2,3; north ch1 = 4,5,6; west ch0 = 7,8,9; west ch1 = 10,11,12; len=3, start.
  - North ch0 per cycle: 1,2,3,0.
  - North ch1 per cycle: 0,4,5,6.
  - West ch0: 7,8,9,0; west ch1: 0,10,11,12.
  - Then 3 zero-bus cycles, all with ce=1 (7 ce cycles total).
  - Then done=1 for exactly 1 cycle.
- len=0: start -> done pulse on the 2nd cycle; ce never asserted; busy stays 0.
- len=40 with BUFFER_LEN=32: clamped; ce high for 32+1+3 = 36 cycles; ch0 streams entries 0..31 with no X or out-of-range read.
- Ignored commands: wr_en to ch0 addr0 (value 99) and start, both issued mid-RUN.
  - The write is ignored: the next run still streams the original value.
  - No second run is triggered.
  - Exactly one done pulse.
- Reset mid-run: assert rst at RUN step 2 -> same cycle ce=0, busy=0, buses=0; no done pulse; buffer reads back 0 afterwards.
- (FEEDER_STALL_EN) stall=1 for 2 cycles at step 1: ce=0 and ch0 holds 2 for those cycles; total ce-high count unchanged at 7; done is delayed by 2 cycles.
